// File: rtl/tl_channel_buffer.sv
// TileLink A/D channel buffer: one independent FIFO lane per direction.
// A lane with depth 0 is a plain wire-through with no state.

module tl_fifo_lane #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_bits,
    output logic [CNT_W-1:0] count
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign out_valid = in_valid;
            assign out_bits  = in_bits;
            assign in_ready  = out_ready;
            assign count     = '0;
        end else begin : g_fifo
            localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

            logic [W-1:0]     mem [DEPTH];
            logic [PTR_W-1:0] head;
            logic [PTR_W-1:0] tail;
            logic [CNT_W-1:0] cnt;
            logic             full;
            logic             empty;
            logic             enq;
            logic             deq;

            // Explicit wrap so non-power-of-two depths stay in range.
            function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
                return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
            endfunction

            assign full      = (cnt == CNT_W'(DEPTH));
            assign empty     = (cnt == '0);
            // Both handshakes depend only on registered state and reset.
            assign in_ready  = !full && !reset;
            assign out_valid = !empty && !reset;
            assign enq       = in_valid && in_ready;
            assign deq       = out_valid && out_ready;
            assign out_bits  = mem[head];
            assign count     = reset ? '0 : cnt;

            always_ff @(posedge clock) begin
                if (reset) begin
                    head <= '0;
                    tail <= '0;
                    cnt  <= '0;
                end else begin
                    if (enq) tail <= wrap_inc(tail);
                    if (deq) head <= wrap_inc(head);
                    case ({enq, deq})
                        2'b10:   cnt <= cnt + 1'b1;
                        2'b01:   cnt <= cnt - 1'b1;
                        default: cnt <= cnt;
                    endcase
                end
            end

            // Payload storage carries no reset.
            always_ff @(posedge clock) begin
                if (enq) mem[tail] <= in_bits;
            end
        end
    endgenerate
endmodule

module tl_channel_buffer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 9,
    parameter int SIZE_W  = 3,
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int MASK_W  = DATA_W / 8,
    parameter int A_CNT_W = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
    parameter int D_CNT_W = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               a_in_valid,
    output logic               a_in_ready,
    input  logic [2:0]         a_in_opcode,
    input  logic [2:0]         a_in_param,
    input  logic [SIZE_W-1:0]  a_in_size,
    input  logic [SRC_W-1:0]   a_in_source,
    input  logic [ADDR_W-1:0]  a_in_address,
    input  logic [MASK_W-1:0]  a_in_mask,
    input  logic [DATA_W-1:0]  a_in_data,
    output logic               a_out_valid,
    input  logic               a_out_ready,
    output logic [2:0]         a_out_opcode,
    output logic [2:0]         a_out_param,
    output logic [SIZE_W-1:0]  a_out_size,
    output logic [SRC_W-1:0]   a_out_source,
    output logic [ADDR_W-1:0]  a_out_address,
    output logic [MASK_W-1:0]  a_out_mask,
    output logic [DATA_W-1:0]  a_out_data,
    input  logic               d_in_valid,
    output logic               d_in_ready,
    input  logic [2:0]         d_in_opcode,
    input  logic [1:0]         d_in_param,
    input  logic [SIZE_W-1:0]  d_in_size,
    input  logic [SRC_W-1:0]   d_in_source,
    input  logic               d_in_denied,
    input  logic               d_in_corrupt,
    input  logic [DATA_W-1:0]  d_in_data,
    output logic               d_out_valid,
    input  logic               d_out_ready,
    output logic [2:0]         d_out_opcode,
    output logic [1:0]         d_out_param,
    output logic [SIZE_W-1:0]  d_out_size,
    output logic [SRC_W-1:0]   d_out_source,
    output logic               d_out_denied,
    output logic               d_out_corrupt,
    output logic [DATA_W-1:0]  d_out_data,
    output logic [A_CNT_W-1:0] a_count,
    output logic [D_CNT_W-1:0] d_count,
    output logic               idle
);
    localparam int A_W = 3 + 3 + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W;
    localparam int D_W = 3 + 2 + SIZE_W + SRC_W + 1 + 1 + DATA_W;

    logic [A_W-1:0] a_in_bits;
    logic [A_W-1:0] a_out_bits;
    logic [D_W-1:0] d_in_bits;
    logic [D_W-1:0] d_out_bits;

    assign a_in_bits = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                        a_in_address, a_in_mask, a_in_data};
    assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
            a_out_address, a_out_mask, a_out_data} = a_out_bits;

    assign d_in_bits = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                        d_in_denied, d_in_corrupt, d_in_data};
    assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
            d_out_denied, d_out_corrupt, d_out_data} = d_out_bits;

    tl_fifo_lane #(.W(A_W), .DEPTH(A_DEPTH), .CNT_W(A_CNT_W)) u_a_lane (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_bits   (a_in_bits),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_bits  (a_out_bits),
        .count     (a_count)
    );

    tl_fifo_lane #(.W(D_W), .DEPTH(D_DEPTH), .CNT_W(D_CNT_W)) u_d_lane (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_bits   (d_in_bits),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_bits  (d_out_bits),
        .count     (d_count)
    );

    // A wire-through lane reports a constant zero count, so it reads as empty.
    assign idle = (a_count == '0) && (d_count == '0);
endmodule

// File: tb/tb_tl_channel_buffer.sv
// Directed bench for tl_channel_buffer: buffered instance (A=2, D=3) with a
// scoreboard on both output channels, plus a wire-through A instance.

module tb_tl_channel_buffer;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Buffered instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0]  a_in_opcode, a_in_param, a_out_opcode, a_out_param;
    logic [2:0]  a_in_size, a_out_size;
    logic [8:0]  a_in_source, a_out_source;
    logic [31:0] a_in_address, a_out_address;
    logic [7:0]  a_in_mask, a_out_mask;
    logic [63:0] a_in_data, a_out_data;
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [2:0]  d_in_opcode, d_out_opcode;
    logic [1:0]  d_in_param, d_out_param;
    logic [2:0]  d_in_size, d_out_size;
    logic [8:0]  d_in_source, d_out_source;
    logic        d_in_denied, d_in_corrupt, d_out_denied, d_out_corrupt;
    logic [63:0] d_in_data, d_out_data;
    logic [1:0]  a_count, d_count;
    logic        idle;

    // Wire-through instance
    logic        w_a_in_valid, w_a_in_ready, w_a_out_valid, w_a_out_ready;
    logic [2:0]  w_a_in_opcode, w_a_in_param, w_a_out_opcode, w_a_out_param;
    logic [2:0]  w_a_in_size, w_a_out_size;
    logic [8:0]  w_a_in_source, w_a_out_source;
    logic [31:0] w_a_in_address, w_a_out_address;
    logic [7:0]  w_a_in_mask, w_a_out_mask;
    logic [63:0] w_a_in_data, w_a_out_data;
    logic        w_d_in_valid, w_d_in_ready, w_d_out_valid, w_d_out_ready;
    logic [2:0]  w_d_out_opcode, w_d_out_size;
    logic [1:0]  w_d_out_param;
    logic [8:0]  w_d_in_source, w_d_out_source;
    logic        w_d_out_denied, w_d_out_corrupt;
    logic [63:0] w_d_out_data;
    logic [0:0]  w_a_count;
    logic [1:0]  w_d_count;
    logic        w_idle;

    tl_channel_buffer #(.A_DEPTH(2), .D_DEPTH(3)) u_dut (
        .clock(clock), .reset(reset),
        .a_in_valid(a_in_valid), .a_in_ready(a_in_ready),
        .a_in_opcode(a_in_opcode), .a_in_param(a_in_param), .a_in_size(a_in_size),
        .a_in_source(a_in_source), .a_in_address(a_in_address),
        .a_in_mask(a_in_mask), .a_in_data(a_in_data),
        .a_out_valid(a_out_valid), .a_out_ready(a_out_ready),
        .a_out_opcode(a_out_opcode), .a_out_param(a_out_param), .a_out_size(a_out_size),
        .a_out_source(a_out_source), .a_out_address(a_out_address),
        .a_out_mask(a_out_mask), .a_out_data(a_out_data),
        .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
        .d_in_opcode(d_in_opcode), .d_in_param(d_in_param), .d_in_size(d_in_size),
        .d_in_source(d_in_source), .d_in_denied(d_in_denied),
        .d_in_corrupt(d_in_corrupt), .d_in_data(d_in_data),
        .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
        .d_out_opcode(d_out_opcode), .d_out_param(d_out_param), .d_out_size(d_out_size),
        .d_out_source(d_out_source), .d_out_denied(d_out_denied),
        .d_out_corrupt(d_out_corrupt), .d_out_data(d_out_data),
        .a_count(a_count), .d_count(d_count), .idle(idle)
    );

    tl_channel_buffer #(.A_DEPTH(0), .D_DEPTH(2)) u_wt (
        .clock(clock), .reset(reset),
        .a_in_valid(w_a_in_valid), .a_in_ready(w_a_in_ready),
        .a_in_opcode(w_a_in_opcode), .a_in_param(w_a_in_param), .a_in_size(w_a_in_size),
        .a_in_source(w_a_in_source), .a_in_address(w_a_in_address),
        .a_in_mask(w_a_in_mask), .a_in_data(w_a_in_data),
        .a_out_valid(w_a_out_valid), .a_out_ready(w_a_out_ready),
        .a_out_opcode(w_a_out_opcode), .a_out_param(w_a_out_param), .a_out_size(w_a_out_size),
        .a_out_source(w_a_out_source), .a_out_address(w_a_out_address),
        .a_out_mask(w_a_out_mask), .a_out_data(w_a_out_data),
        .d_in_valid(w_d_in_valid), .d_in_ready(w_d_in_ready),
        .d_in_opcode(3'd1), .d_in_param(2'd0), .d_in_size(3'd3),
        .d_in_source(w_d_in_source), .d_in_denied(1'b0),
        .d_in_corrupt(1'b0), .d_in_data(64'h0),
        .d_out_valid(w_d_out_valid), .d_out_ready(w_d_out_ready),
        .d_out_opcode(w_d_out_opcode), .d_out_param(w_d_out_param), .d_out_size(w_d_out_size),
        .d_out_source(w_d_out_source), .d_out_denied(w_d_out_denied),
        .d_out_corrupt(w_d_out_corrupt), .d_out_data(w_d_out_data),
        .a_count(w_a_count), .d_count(w_d_count), .idle(w_idle)
    );

    int vectors = 0;
    int errors  = 0;
    logic [121:0] a_exp [$];
    logic [82:0]  d_exp [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic push_a;
        a_exp.push_back({a_in_opcode, a_in_param, a_in_size, a_in_source,
                         a_in_address, a_in_mask, a_in_data});
    endtask

    task automatic push_d;
        d_exp.push_back({d_in_opcode, d_in_param, d_in_size, d_in_source,
                         d_in_denied, d_in_corrupt, d_in_data});
    endtask

    // Monitor: every beat leaving the buffered instance must match the queue head.
    always @(negedge clock) begin
        if (!reset && a_out_valid && a_out_ready) begin
            if (a_exp.size() == 0) begin
                vectors++; errors++;
                $display("FAIL a_unexpected: got beat data %0h expected none", a_out_data);
            end else
                chk("a_beat", {6'd0, a_out_opcode, a_out_param, a_out_size, a_out_source,
                               a_out_address, a_out_mask, a_out_data}, {6'd0, a_exp.pop_front()});
        end
        if (!reset && d_out_valid && d_out_ready) begin
            if (d_exp.size() == 0) begin
                vectors++; errors++;
                $display("FAIL d_unexpected: got beat source %0h expected none", d_out_source);
            end else
                chk("d_beat", {45'd0, d_out_opcode, d_out_param, d_out_size, d_out_source,
                               d_out_denied, d_out_corrupt, d_out_data}, {45'd0, d_exp.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_out_ready = 0; d_in_valid = 0; d_out_ready = 0;
        a_in_opcode = 3'd4; a_in_param = 3'd0; a_in_size = 3'd3; a_in_source = 9'h1A5;
        a_in_address = 32'h8000_0040; a_in_mask = 8'hFF; a_in_data = 64'hDEADBEEF_01234567;
        d_in_opcode = 3'd1; d_in_param = 2'd0; d_in_size = 3'd3; d_in_source = 9'd0;
        d_in_denied = 0; d_in_corrupt = 0; d_in_data = 64'h0;
        w_a_in_valid = 0; w_a_out_ready = 0; w_a_in_opcode = 0; w_a_in_param = 0;
        w_a_in_size = 0; w_a_in_source = 0; w_a_in_address = 0; w_a_in_mask = 0;
        w_a_in_data = 0; w_d_in_valid = 0; w_d_out_ready = 0; w_d_in_source = 0;

        // Reset state
        step; step;
        @(negedge clock);
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_d_in_ready", d_in_ready, 0);
        chk("rst_idle", idle, 1);
        chk("rst_a_count", a_count, 0);
        step; reset = 0;
        @(negedge clock);
        chk("post_rst_a_in_ready", a_in_ready, 1);
        chk("post_rst_d_in_ready", d_in_ready, 1);

        // 1. Single beat, one-cycle latency, no flow-through
        step; a_in_valid = 1; a_out_ready = 1; push_a;
        @(negedge clock);
        chk("t1_no_flow_through", a_out_valid, 0);
        chk("t1_count0", a_count, 0);
        step; a_in_valid = 0;
        @(negedge clock);
        chk("t1_valid_next", a_out_valid, 1);
        chk("t1_count1", a_count, 1);
        step;
        @(negedge clock);
        chk("t1_count_back0", a_count, 0);
        chk("t1_valid_low", a_out_valid, 0);

        // 2. Fill and backpressure
        step; a_out_ready = 0; a_in_valid = 1; a_in_data = 64'd1; push_a;
        @(negedge clock); chk("t2_rdy_b1", a_in_ready, 1);
        step; a_in_data = 64'd2; push_a;
        @(negedge clock); chk("t2_rdy_b2", a_in_ready, 1); chk("t2_cnt1", a_count, 1);
        step; a_in_data = 64'd3; push_a;
        @(negedge clock); chk("t2_full_rdy", a_in_ready, 0); chk("t2_cnt2", a_count, 2);
        step; a_out_ready = 1;
        @(negedge clock); chk("t2_full_deq_rdy", a_in_ready, 0); chk("t2_cnt2b", a_count, 2);
        step;
        @(negedge clock); chk("t2_rdy_after_deq", a_in_ready, 1); chk("t2_cnt1b", a_count, 1);
        step; a_in_valid = 0;
        @(negedge clock); chk("t2_cnt1c", a_count, 1);
        step;
        @(negedge clock); chk("t2_drained", a_count, 0);

        // 3. D streaming across pointer wrap (depth 3)
        step; d_out_ready = 1; d_in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step;
            d_in_source = 9'(i); d_in_data = 64'(i * 3 + 100); push_d;
            @(negedge clock);
            chk("t3_d_in_ready", d_in_ready, 1);
            chk("t3_d_count", d_count, (i == 0) ? 0 : 1);
            chk("t3_d_out_valid", d_out_valid, (i == 0) ? 0 : 1);
        end
        step; d_in_valid = 0;
        @(negedge clock); chk("t3_tail_count", d_count, 1);
        step;
        @(negedge clock); chk("t3_empty", d_count, 0);

        // 4. Reset mid-operation discards buffered beats
        step; d_out_ready = 0; d_in_valid = 1; d_in_denied = 1; d_in_source = 9'h55;
        step; d_in_source = 9'h56;
        step; d_in_valid = 0; d_in_denied = 0;
        @(negedge clock); chk("t4_count2", d_count, 2); chk("t4_idle0", idle, 0);
        step; reset = 1; d_out_ready = 1;
        @(negedge clock);
        chk("t4_rst_valid", d_out_valid, 0);
        chk("t4_rst_count", d_count, 0);
        chk("t4_rst_idle", idle, 1);
        chk("t4_rst_ready", d_in_ready, 0);
        step; reset = 0;
        @(negedge clock);
        chk("t4_post_ready", d_in_ready, 1);
        chk("t4_post_valid", d_out_valid, 0);
        step; step;
        @(negedge clock); chk("t4_still_empty", d_count, 0);

        // 5. Wire-through A on the depth-0 instance
        for (int i = 0; i < 4; i++) begin
            step;
            w_a_in_valid = i[0]; w_a_out_ready = i[1];
            w_a_in_address = 32'h1000_0000 + 32'(i * 'h44);
            w_a_in_data = 64'hA5A5_0000_0000_0000 + 64'(i);
            w_a_in_source = 9'(i + 7); w_a_in_mask = 8'(8'h0F << i);
            #1;
            chk("t5_addr", w_a_out_address, 32'h1000_0000 + 32'(i * 'h44));
            chk("t5_data", w_a_out_data, 64'hA5A5_0000_0000_0000 + 64'(i));
            chk("t5_src", w_a_out_source, 9'(i + 7));
            chk("t5_mask", w_a_out_mask, 8'(8'h0F << i));
            chk("t5_valid", w_a_out_valid, i[0]);
            chk("t5_ready", w_a_in_ready, i[1]);
            @(negedge clock);
            chk("t5_count", w_a_count, 0);
            chk("t5_idle_d_empty", w_idle, 1);
        end
        step; w_a_out_ready = 1; w_a_in_valid = 1; w_d_in_valid = 1;
        @(negedge clock); chk("t5_wt_ready_comb", w_a_in_ready, 1);
        step; w_d_in_valid = 0;
        @(negedge clock); chk("t5_idle_d_busy", w_idle, 0);
        step; w_d_out_ready = 1; w_a_in_valid = 0;
        step;
        @(negedge clock); chk("t5_idle_d_drained", w_idle, 1);

        // 6. Independence: A stalled full while D streams
        step; a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h100; push_a;
        step; a_in_data = 64'h101; push_a;
        step; a_in_valid = 0; d_out_ready = 1; d_in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step;
            d_in_source = 9'(9'h40 + i); d_in_data = 64'(i + 64'h7000); push_d;
            @(negedge clock);
            chk("t6_d_ready", d_in_ready, 1);
            chk("t6_a_full", a_count, 2);
            chk("t6_idle0", idle, 0);
        end
        step; d_in_valid = 0; a_out_ready = 1;
        begin
            bit drained = 0;
            for (int i = 0; i < 20 && !drained; i++) begin
                @(negedge clock);
                if (idle) drained = 1;
                else step;
            end
            chk("t6_idle_after_drain", drained, 1);
        end

        step;
        chk("a_queue_empty", a_exp.size(), 0);
        chk("d_queue_empty", d_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/tl_channel_buffer.md
Name: tl_channel_buffer

Overview:
- Parametrised TileLink A/D channel buffer; each direction gets an independent FIFO of configurable depth.
- Successor to the plain wire-through channel adaptor used between the core bus and the AXI4 bridge.
- Depth 0 on a channel degenerates to a pure wire-through for that channel.
- Adds registered decoupling, per-channel occupancy reporting and a drain-status flag.

Parameters:
- ADDR_W, 32, A-channel address width
- DATA_W, 64, data width on both channels; MASK_W = DATA_W/8
- SRC_W, 9, source ID width
- SIZE_W, 3, size field width
- A_DEPTH, 2, A-channel FIFO entries (0 = wire-through, otherwise 1..16)
- D_DEPTH, 2, D-channel FIFO entries (0 = wire-through, otherwise 1..16)

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- a_in_valid / a_in_ready  in/out  1  upstream A handshake
- a_in_opcode, a_in_param  in  3, 3  A opcode, param
- a_in_size  in  SIZE_W
- a_in_source  in  SRC_W
- a_in_address  in  ADDR_W
- a_in_mask  in  MASK_W
- a_in_data  in  DATA_W
- a_out_*  out (ready in)  same widths  downstream A, same field set
- d_in_valid / d_in_ready  in/out  1  downstream-side D handshake
- d_in_opcode 3, d_in_param 2, d_in_size SIZE_W, d_in_source SRC_W  in  D fields
- d_in_denied, d_in_corrupt  in  1  D flags
- d_in_data  in  DATA_W
- d_out_*  out (ready in)  same widths  upstream D
- a_count  out  clog2(A_DEPTH+1)  A occupancy
- d_count  out  clog2(D_DEPTH+1)  D occupancy
- idle  out  1  both FIFOs empty

Behaviour:
- Per channel with DEPTH>=1: circular FIFO with head/tail pointers and an occupancy counter.
- Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready.
- in_ready = !full && !reset. It is registered-state-derived only: there is no combinational path from out_ready to in_ready.
- out_valid = !empty. Payload outputs are driven from the head entry.
- Minimum latency is 1 cycle: a beat accepted at edge N is visible at out_* in cycle N+1. There is no same-cycle flow-through.
- Full with out_ready=1: dequeue happens and in_ready stays 0 that cycle. The new beat is accepted the following cycle.
- Empty with in_valid=1: enqueue only; out_valid rises the next cycle.
- Simultaneous enqueue and dequeue when neither full nor empty: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Non-power-of-2 depths must work: explicit wrap at DEPTH-1.
- Payload storage is not reset. out_* payload is don't-care whenever out_valid=0.
- Order is preserved strictly per channel. The A and D channels are fully independent, with no cross-channel ordering.
- DEPTH=0: out_* = in_* combinationally, in_ready = out_ready, count = 0.
- Reset (any cycle, including mid-transfer): count, head and tail go to 0; out_valid=0, in_ready=0, a_count=d_count=0, idle=1 while reset is high. All buffered beats are discarded. in_ready=1 in the first cycle after reset deasserts.
- idle = (a_count==0) && (d_count==0). With a channel in DEPTH=0 mode, that channel contributes empty.
- Protocol fields pass unmodified: no decoding, no checking of opcode, mask or size legality.

Test Plan:
1. Single beat: A_DEPTH=2. Reset, then a_in beat addr=0x8000_0040, data=0xDEADBEEF_01234567, mask=0xFF, source=0x1A5, a_out_ready=1 -> a_out_valid=1 exactly one cycle later with identical fields; a_count goes 0->1->0.
2. Fill/backpressure: a_out_ready=0, offer 3 beats with data=1,2,3 -> beats 1 and 2 accepted, a_in_ready=0 with a_count=2; raise ready -> outputs 1, 2, then 3 in order, with beat 3 accepted the cycle after the first dequeue.
3. Streaming: D_DEPTH=3, d_in_valid and d_out_ready held 1 for 20 beats (source incrementing 0..19) -> sustained 1 beat/cycle after 1-cycle fill, d_count steady at 1, order intact across pointer wrap.
4. Reset mid-operation: D holds 2 beats (denied=1, corrupt=0) -> assert reset for 1 cycle -> d_out_valid=0, d_count=0, idle=1, d_in_ready=0 during reset and 1 the cycle after; the old beats never appear.
5. Wire-through: A_DEPTH=0 -> a_out_* tracks a_in_* in the same cycle, a_in_ready follows a_out_ready combinationally, a_count stays 0, idle depends only on D.
6. Independence: A stalled full while D streams 5 beats -> D unaffected; idle=0 until A drains.
